// File: rtl/sprite_mover_if.sv
// Pixel-stream bundle between the sync generator side and the sprite mover.
// The master drives the pixel coordinate and frame controls, and the slave
// returns the sprite hit/offset signals and the current position.
interface sprite_mover_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       visible;
  logic       new_frame;
  logic       pause;
  logic       sprite_hit;
  logic [3:0] sprite_line;
  logic [3:0] sprite_col;
  logic       bounce;
  logic [9:0] pos_x;
  logic [9:0] pos_y;

  modport master (
    output x, y, visible, new_frame, pause,
    input  sprite_hit, sprite_line, sprite_col, bounce, pos_x, pos_y
  );

  modport slave (
    input  x, y, visible, new_frame, pause,
    output sprite_hit, sprite_line, sprite_col, bounce, pos_x, pos_y
  );
endinterface

// File: rtl/sprite_mover.sv
// Sprite position tracker. The sprite moves once per frame, bounces off the
// screen edges, and gets a one-cycle-latency "inside sprite" flag with its
// 4-bit row/column offsets for the bitmap ROM.
module sprite_mover #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned SPEED     = 1,
  parameter int unsigned INIT_X    = 100,
  parameter int unsigned INIT_Y    = 50
) (
  input logic           clk,
  input logic           reset_n,
  sprite_mover_if.slave bus
);

  // A movement step happens only on unpaused frame pulses.
  logic do_move;
  assign do_move = bus.new_frame && !bus.pause;

  // Index 0 is the X axis and index 1 is the Y axis. Both axes use the same
  // bounce logic, and each one has its own limit and starting value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam logic [10:0] MAX  = 11'((gi == 0) ? H_VISIBLE - 16 : V_VISIBLE - 16);
    localparam logic [10:0] STEP = 11'(SPEED);
    localparam logic [9:0]  INIT = 10'((gi == 0) ? INIT_X : INIT_Y);

    logic [9:0]  coord;
    logic [9:0]  pos_q, pos_d;
    logic        dir_q, dir_d;   // 1 = increasing
    logic        bounced;
    logic        in_axis;
    logic [3:0]  offs;
    logic [10:0] pos_ext;
    logic [10:0] coord_ext;
    logic [10:0] sum_ext;
    logic [10:0] diff_ext;

    assign coord     = (gi == 0) ? bus.x : bus.y;
    assign pos_ext   = {1'b0, pos_q};
    assign coord_ext = {1'b0, coord};
    assign sum_ext   = pos_ext + STEP;
    assign diff_ext  = pos_ext - STEP;

    // The span test is done at 11 bits so that pos+16 can never wrap.
    // Only the low bits of the offset are needed, so a 4-bit subtract is enough.
    assign in_axis = (coord_ext >= pos_ext) && (coord_ext < pos_ext + 11'd16);
    assign offs    = coord[3:0] - pos_q[3:0];

    // Next position/direction: step toward the current direction and clamp
    // to the edge, reversing direction when the edge is reached.
    always_comb begin
      pos_d   = pos_q;
      dir_d   = dir_q;
      bounced = 1'b0;
      if (do_move) begin
        if (dir_q) begin
          if (sum_ext >= MAX) begin
            pos_d   = MAX[9:0];
            dir_d   = 1'b0;
            bounced = 1'b1;
          end else begin
            pos_d = sum_ext[9:0];
          end
        end else begin
          if (pos_ext <= STEP) begin
            pos_d   = '0;
            dir_d   = 1'b1;
            bounced = 1'b1;
          end else begin
            pos_d = diff_ext[9:0];
          end
        end
      end
    end

    // Per-axis position and direction state.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pos_q <= INIT;
        dir_q <= 1'b1;
      end else begin
        pos_q <= pos_d;
        dir_q <= dir_d;
      end
    end
  end

  // The hit test uses the pre-update position because pos_q changes only at the edge.
  logic       hit_c;
  logic       hit_q;
  logic [3:0] col_q;
  logic [3:0] line_q;
  logic       bounce_q;

  assign hit_c = bus.visible && g_axis[0].in_axis && g_axis[1].in_axis;

  // Register the hit flag and offsets (zeroed outside the sprite), and make a
  // single bounce pulse when either axis reflects, including a corner hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q    <= 1'b0;
      col_q    <= '0;
      line_q   <= '0;
      bounce_q <= 1'b0;
    end else begin
      hit_q    <= hit_c;
      col_q    <= hit_c ? g_axis[0].offs : 4'd0;
      line_q   <= hit_c ? g_axis[1].offs : 4'd0;
      bounce_q <= g_axis[0].bounced | g_axis[1].bounced;
    end
  end

  assign bus.sprite_hit  = hit_q;
  assign bus.sprite_col  = col_q;
  assign bus.sprite_line = line_q;
  assign bus.bounce      = bounce_q;
  assign bus.pos_x       = g_axis[0].pos_q;
  assign bus.pos_y       = g_axis[1].pos_q;

endmodule
